// File: rtl/ones_cnt_dispatcher.sv
// Buffers upstream words and issues them one at a time to the ones counter via start/data_out; a word leaves on start&&rdy.
// Head word is presented the cycle after it lands in an empty FIFO; in_ready drops only on full, flush or reset.
module ones_cnt_dispatcher #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   start,
    output logic [DATA_W-1:0]      data_out,
    input  logic                   rdy,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       issued_cnt,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_gap;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_issued;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_more;
    logic [AW:0] w_level;
    logic [AW:0] w_level_nxt;

    // Same index with differing wrap bit means the tail has lapped the head.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign in_ready    = !w_full && !flush && !rst;
    assign w_push      = in_valid && in_ready;
    assign start       = (r_state == S_ISSUE) && !flush;
    assign w_pop       = start && rdy;
    assign data_out    = start ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);
    assign w_more      = (w_level_nxt != '0);

    assign level      = w_level;
    assign issued_cnt = r_issued;
    assign busy       = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gap    <= 4'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_issued <= '0;
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_gap    <= 4'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
                r_issued <= r_issued + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_more) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_pop) begin
                        if (HOLDOFF > 0) begin
                            r_state <= S_GAP;
                            r_gap   <= 4'(HOLDOFF);
                        end else if (!w_more) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 4'd1;
                    if (r_gap <= 4'd1) begin
                        r_state <= w_more ? S_ISSUE : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ones_cnt_dispatcher.md
Name: ones_cnt_dispatcher

Overview:
Upstream feeder for the ones-counter datapath/controller pair. It accepts words on a valid/ready input, buffers them in a small FIFO, and presents them one at a time on the counter's start/data_in interface. A word counts as dispatched when the counter returns rdy while start is high. An optional hold-off spaces successive issues, and an issued-word counter supports performance checks.

Parameters:
DATA_W, 8, word width; must equal the counter's data_size
DEPTH, 4, FIFO entries; power of 2, at least 2
HOLDOFF, 0, idle cycles forced between an accepted issue and the next start assertion; range 0..15
CNT_W, 16, width of issued_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream word valid
in_data  in  DATA_W  upstream word
in_ready  out  1  FIFO can accept this cycle
flush  in  1  synchronous discard of all buffered words
start  out  1  to counter start; request to issue the head word
data_out  out  DATA_W  to counter data_in; head word while start=1, else 0
rdy  in  1  from counter; high with start means the word is accepted
level  out  $clog2(DEPTH)+1  current FIFO occupancy
issued_cnt  out  CNT_W  total accepted issues, wraps modulo 2^CNT_W
busy  out  1  high when state is not S_IDLE or level is not 0

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (rst=1, asynchronous):
  - FIFO is emptied; level=0, issued_cnt=0, state=S_IDLE, gap counter=0.
  - start=0, data_out=0, busy=0.
  - in_ready=0 while rst=1.
- Push:
  - in_ready = !full && !flush && !rst. It does not depend combinationally on rdy.
  - A push happens when in_valid && in_ready. The word is written at the tail on that clock edge.
- Issue state machine (registered state):
  - S_IDLE: start=0. Go to S_ISSUE at the next edge if the FIFO is non-empty after that edge's push/pop and flush=0.
  - S_ISSUE: start = !flush; data_out = head word.
    - On start && rdy: pop the head and increment issued_cnt.
    - After an accept, with HOLDOFF>0: go to S_GAP and load the gap counter with HOLDOFF.
    - After an accept, with HOLDOFF=0: stay in S_ISSUE if words remain, otherwise go to S_IDLE.
    - Without rdy: stay in S_ISSUE. The head word is held stable until rdy.
  - S_GAP: start=0. Decrement the gap counter each cycle. When it reaches 1, go to S_ISSUE if the FIFO is non-empty, otherwise to S_IDLE.
  - Illegal state encoding: go to S_IDLE.
- Latency:
  - A word pushed into an empty FIFO in S_IDLE is presented with start=1 on the cycle after the push edge.
  - Minimum spacing between accepted issues is 1+HOLDOFF cycles. The counter's own running period further throttles this through rdy.
- Simultaneous push and pop: allowed whenever the FIFO is not full; level is unchanged. When full, in_ready=0, so there is no push in that cycle even if a pop occurs.
- Flush:
  - start is forced to 0 while flush=1, so no accept can coincide with a flush.
  - At the edge: FIFO cleared, level=0, state goes to S_IDLE, gap counter cleared. issued_cnt is kept.
  - A push is also blocked because in_ready=0.
- Wrap:
  - FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by the extra pointer bit.
  - issued_cnt wraps from 2^CNT_W-1 to 0.
- rdy while start=0 is ignored.
- Reset mid-issue: everything clears immediately and the buffered words are lost. The counter's own reset governs its side.

Test Plan:
- Reset, push 0xA5, hold rdy=1 -> start=1 and data_out=0xA5 one cycle after the push. Accept that cycle; issued_cnt=1, level=0, start=0 on the next cycle.
- Push 4 words 0x01,0x02,0x03,0x04 with rdy=0 (DEPTH=4) -> level=4, in_ready=0. A 5th in_valid is not accepted. data_out stays 0x01 until rdy.
- HOLDOFF=2, 3 words buffered, rdy tied 1 -> start pulses accepted on cycles t, t+3, t+6; issued_cnt=3.
- Full FIFO, one pop via rdy, and in_valid on the following cycle -> push accepted, level back to 4. Order out: 0x02,0x03,0x04, then the new word.
- flush asserted with 3 words buffered and state S_ISSUE -> start=0 during flush, level=0 after the edge, state S_IDLE, issued_cnt unchanged.
- rst pulsed mid-stream with level=2 and start=1 -> start=0, level=0, issued_cnt=0 immediately, without waiting for a clock edge.
